bit_to_value_converter: RTL and testbench
=========================================

Name: bit_to_value_converter

Overview:
- Inverse of the value-to-bit-place converter; rebuilds an 8-bit value from a stream of set-bit positions.
- Input is one bit place per beat, MSB first, with a last marker and a zero-value marker.
- When a value's final beat arrives, the block presents the reconstructed value and its popcount on a valid/ready output.
- Sits at the consumer end of the bit-sparse datapath, just before dense accumulators and the result writeback.

Parameters:
- VALUE_W, 8, width of the reconstructed value.
- PLACE_W, 3, width of a bit place; equals clog2(VALUE_W).

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- InValid  in  1  bit-place beat valid.
- InReady  out  1  block accepts a beat this cycle.
- InPlace  in  PLACE_W  position of a set bit.
- InLast  in  1  final beat of the current value.
- InEmpty  in  1  value is zero; the beat carries no place and implies last.
- OutValid  out  1  reconstructed value available.
- OutReady  in  1  downstream takes the value.
- OutValue  out  VALUE_W  reconstructed value.
- OutCount  out  PLACE_W+1  number of places accepted for this value.
- OutError  out  1  place-order violation; tied 0 unless the macro is defined.

Behaviour:
- Reset: asynchronous on RSTN low.
  - State goes to S_COLLECT.
  - Accumulator, count and OutValue/OutCount go to 0.
  - OutValid=0, OutError=0, InReady=1 once RSTN is released.
  - Reset mid-value discards any partial accumulation.
- S_COLLECT:
  - InReady=1, OutValid=0.
  - A beat is taken when InValid&InReady.
  - InEmpty=1: InPlace and InLast are ignored; the result is acc OR 0; go to S_OUTPUT.
  - Otherwise acc[InPlace]<=1 and count<=count+1.
  - If InLast=1: register OutValue=acc|onehot(InPlace) and OutCount=count+1, then go to S_OUTPUT.
- S_OUTPUT:
  - InReady=0, OutValid=1; OutValue, OutCount and OutError are held stable.
  - On OutReady=1: clear acc, count and the error state; return to S_COLLECT.
  - InReady rises the next cycle; there is no same-cycle bypass.
- Latency:
  - The last beat accepted at edge N gives OutValid=1 after edge N.
  - The earliest next accepted beat is one cycle after the handshake; throughput is one value per (beats+1) cycles.
- Duplicate place:
  - The bit stays set (idempotent OR).
  - The count still increments, so OutCount can exceed popcount(OutValue).
- Count saturation: OutCount saturates at VALUE_W.
- InEmpty with a non-empty accumulator (protocol misuse): the accumulated bits are still output.
- Inputs are sampled only when the handshake fires; InPlace is don't-care otherwise.

Optional Feature:
- Macro: BTV_ORDER_CHECK_EN.
- Defined:
  - The block holds the previous place of the current value.
  - Any non-first beat with InPlace >= the previous place sets a sticky error, presented as OutError with the value and cleared on the output handshake.
  - Duplicates therefore flag an error.
- Undefined: no previous-place register; OutError is constant 0.
- Reconstruction behaviour is identical in both cases.

Decomposition:
- Package bit_sparsity_pkg holds:
  - VALUE_W and PLACE_W constants.
  - The state enum {S_COLLECT, S_OUTPUT}.
  - A beat struct {place, last, empty}.
- Sub-module place_to_onehot: combinational PLACE_W-to-VALUE_W one-hot decoder, reusable by other converters.

Test Plan:
1. Beats 7,5,2,0 (last on 0), OutReady=1 -> OutValue=0xA5, OutCount=4, OutValid high exactly one cycle after the last beat, OutError=0.
2. Single beat InEmpty=1 -> OutValue=0x00, OutCount=0.
3. Single beat place 7 with last, OutReady held low 5 cycles -> OutValue=0x80 stable, InReady=0 throughout; the handshake on cycle 6 makes InReady=1 the next cycle.
4. Beats 2,5 (last) -> OutValue=0x24, OutCount=2; OutError=1 with BTV_ORDER_CHECK_EN defined, 0 without.
5. Beats 7,6, then RSTN pulsed low, then beat 0 with last -> OutValue=0x01, OutCount=1.
6. Back-to-back values 0x03 (1,0) and 0x80 (7) with OutReady tied 1 -> outputs 0x03 then 0x80, with one idle InReady=0 cycle between them.

Source files
------------

// File: rtl/bit_sparsity_pkg.sv
// Shared types and constants for the bit-sparse datapath converters.
// Optional place-order checking is enabled with the BTV_ORDER_CHECK_EN macro.
package bit_sparsity_pkg;

   localparam int unsigned VALUE_W = 8;
   localparam int unsigned PLACE_W = $clog2(VALUE_W);

   typedef enum logic {
      S_COLLECT,
      S_OUTPUT
   } state_e;

   typedef struct packed {
      logic [PLACE_W-1:0] place;
      logic               last;
      logic               empty;
   } beat_t;

   localparam logic [PLACE_W:0] CNT_ONE = (PLACE_W+1)'(1);
   localparam logic [PLACE_W:0] CNT_MAX = (PLACE_W+1)'(VALUE_W);

   // Place counter increment that sticks at VALUE_W.
   function automatic logic [PLACE_W:0] sat_inc(input logic [PLACE_W:0] cnt);
      if (cnt >= CNT_MAX) begin
         return CNT_MAX;
      end
      return cnt + CNT_ONE;
   endfunction

endpackage

// File: rtl/bit_to_value_converter_if.sv
// Beat input and reconstructed-value output channels of bit_to_value_converter.
// OutError only carries information when BTV_ORDER_CHECK_EN is defined.
interface bit_to_value_converter_if;
   import bit_sparsity_pkg::*;

   logic               InValid;
   logic               InReady;
   logic [PLACE_W-1:0] InPlace;
   logic               InLast;
   logic               InEmpty;
   logic               OutValid;
   logic               OutReady;
   logic [VALUE_W-1:0] OutValue;
   logic [PLACE_W:0]   OutCount;
   logic               OutError;

   modport slave (
      input  InValid, InPlace, InLast, InEmpty, OutReady,
      output InReady, OutValid, OutValue, OutCount, OutError
   );

   modport master (
      output InValid, InPlace, InLast, InEmpty, OutReady,
      input  InReady, OutValid, OutValue, OutCount, OutError
   );

endinterface

// File: rtl/place_to_onehot.sv
// Combinational bit-place to one-hot decoder; all zeros when not enabled.
module place_to_onehot
   import bit_sparsity_pkg::*;
#(
   parameter int unsigned VALUE_W_P = VALUE_W,
   parameter int unsigned PLACE_W_P = PLACE_W
) (
   input  logic [PLACE_W_P-1:0] place,
   input  logic                 en,
   output logic [VALUE_W_P-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot = VALUE_W_P'(1) << place;
      end
   end

endmodule

// File: rtl/bit_to_value_converter.sv
// Rebuilds a dense value from MSB-first set-bit places; emits value and place count.
// Define BTV_ORDER_CHECK_EN to flag non-descending places on OutError.
module bit_to_value_converter
   import bit_sparsity_pkg::*;
(
   input logic                      CLK,
   input logic                      RSTN,
   bit_to_value_converter_if.slave  bus
);

   state_e             state;
   logic [VALUE_W-1:0] acc;
   logic [PLACE_W:0]   count;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [VALUE_W-1:0] out_value_q;
   logic [PLACE_W:0]   out_count_q;

   beat_t              beat;
   logic               beat_fire;
   logic               beat_done;
   logic               out_fire;
   logic [VALUE_W-1:0] place_bit;
   logic [VALUE_W-1:0] acc_next;
   logic [PLACE_W:0]   count_next;

   assign beat = '{place: bus.InPlace, last: bus.InLast, empty: bus.InEmpty};

   assign beat_fire = (state == S_COLLECT) && bus.InValid;
   assign beat_done = beat_fire && (beat.empty || beat.last);
   assign out_fire  = (state == S_OUTPUT) && bus.OutReady;

   place_to_onehot #(
      .VALUE_W_P (VALUE_W),
      .PLACE_W_P (PLACE_W)
   ) u_decode (
      .place  (beat.place),
      .en     (!beat.empty),
      .onehot (place_bit)
   );

   // An empty beat contributes no bit and no count.
   assign acc_next   = acc | place_bit;
   assign count_next = beat.empty ? count : sat_inc(count);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state       <= S_COLLECT;
         acc         <= '0;
         count       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_count_q <= '0;
      end else begin
         unique case (state)
            S_COLLECT: begin
               if (beat_fire) begin
                  acc   <= acc_next;
                  count <= count_next;
                  if (beat_done) begin
                     out_value_q <= acc_next;
                     out_count_q <= count_next;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state       <= S_OUTPUT;
                  end
               end
            end
            S_OUTPUT: begin
               if (out_fire) begin
                  acc         <= '0;
                  count       <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= S_COLLECT;
               end
            end
            default: begin
               state <= S_COLLECT;
            end
         endcase
      end
   end

   assign bus.InReady  = in_ready_q;
   assign bus.OutValid = out_valid_q;
   assign bus.OutValue = out_value_q;
   assign bus.OutCount = out_count_q;

`ifdef BTV_ORDER_CHECK_EN
   logic [PLACE_W-1:0] prev_place;
   logic               err_sticky;
   logic               out_error_q;
   logic               order_viol;

   // A zero count means no placed beat yet, so the first place is never compared.
   assign order_viol = beat_fire && !beat.empty && (count != '0) && (beat.place >= prev_place);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         prev_place  <= '0;
         err_sticky  <= 1'b0;
         out_error_q <= 1'b0;
      end else begin
         if (beat_fire && !beat.empty) begin
            prev_place <= beat.place;
         end
         if (out_fire) begin
            err_sticky <= 1'b0;
         end else if (order_viol) begin
            err_sticky <= 1'b1;
         end
         if (beat_done) begin
            out_error_q <= err_sticky || order_viol;
         end
      end
   end

   assign bus.OutError = out_error_q;
`else
   assign bus.OutError = 1'b0;
`endif

endmodule

// File: tb/tb_bit_to_value_converter.sv
// Table-driven and scoreboard bench for bit_to_value_converter.
module tb_bit_to_value_converter;

`ifdef BTV_ORDER_CHECK_EN
   localparam logic ORD = 1'b1;
`else
   localparam logic ORD = 1'b0;
`endif

   typedef struct {
      logic [7:0] val;
      logic [3:0] cnt;
      logic       err;
   } exp_t;

   typedef struct {
      int              n;
      logic [3:0][2:0] pl;
      logic            empty;
      logic [7:0]      val;
      logic [3:0]      cnt;
      logic            err;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   vec_t vecs[6];

   bit_to_value_converter_if bif ();

   bit_to_value_converter dut (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic push(input logic [7:0] v, input logic [3:0] c, input logic e);
      exp_t x;
      x.val = v;
      x.cnt = c;
      x.err = e;
      exp_q.push_back(x);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(input logic [2:0] p, input logic l, input logic e,
                            output int acc_cyc);
      int t = 0;
      bif.InValid = 1'b1;
      bif.InPlace = p;
      bif.InLast  = l;
      bif.InEmpty = e;
      @(negedge clk);
      while (!bif.InReady && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++;
         n_fail++;
         $display("FAIL beat_timeout: InReady got 0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      bif.InValid = 1'b0;
      bif.InPlace = 3'($urandom_range(0, 7));
   endtask

   // Scoreboard: compare every output handshake against the oldest expectation.
   always @(negedge clk) begin
      if (rstn && bif.OutValid && bif.OutReady) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got value 0x%0h, expected no output", bif.OutValue);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            check("sb_value", 32'(bif.OutValue), 32'(x.val));
            check("sb_count", 32'(bif.OutCount), 32'(x.cnt));
            check("sb_error", 32'(bif.OutError), 32'(x.err));
         end
      end
   end

   initial begin
      int c0;
      int c1;
      int t;
      logic [2:0] p;

      vecs[0] = '{n: 4, pl: {3'd0, 3'd2, 3'd5, 3'd7}, empty: 1'b0, val: 8'hA5, cnt: 4'd4, err: 1'b0};
      vecs[1] = '{n: 0, pl: '0, empty: 1'b1, val: 8'h00, cnt: 4'd0, err: 1'b0};
      vecs[2] = '{n: 2, pl: {3'd0, 3'd0, 3'd5, 3'd2}, empty: 1'b0, val: 8'h24, cnt: 4'd2, err: ORD};
      vecs[3] = '{n: 1, pl: {3'd0, 3'd0, 3'd0, 3'd7}, empty: 1'b0, val: 8'h80, cnt: 4'd1, err: 1'b0};
      vecs[4] = '{n: 2, pl: {3'd0, 3'd0, 3'd0, 3'd1}, empty: 1'b0, val: 8'h03, cnt: 4'd2, err: 1'b0};
      vecs[5] = '{n: 3, pl: {3'd0, 3'd4, 3'd4, 3'd4}, empty: 1'b0, val: 8'h10, cnt: 4'd3, err: ORD};

      rstn         = 1'b0;
      bif.InValid  = 1'b0;
      bif.InPlace  = '0;
      bif.InLast   = 1'b0;
      bif.InEmpty  = 1'b0;
      bif.OutReady = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bif.OutValid), 32'd0);
      check("rst_out_value", 32'(bif.OutValue), 32'd0);
      check("rst_out_count", 32'(bif.OutCount), 32'd0);
      check("rst_out_error", 32'(bif.OutError), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(bif.InReady), 32'd1);
      @(posedge clk);
      #1;
      bif.OutReady = 1'b1;

      // Table vectors with OutReady held high
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].val, vecs[i].cnt, vecs[i].err);
         for (int j = 0; j < vecs[i].n; j++) begin
            send_beat(vecs[i].pl[j], (j == vecs[i].n - 1), 1'b0, c0);
         end
         if (vecs[i].empty) begin
            send_beat(3'd3, 1'b1, 1'b1, c0);
         end
         @(negedge clk);
         check("lat_valid", 32'(bif.OutValid), 32'd1);
         check("lat_in_ready", 32'(bif.InReady), 32'd0);
         @(posedge clk);
         #1;
         @(negedge clk);
         check("post_valid", 32'(bif.OutValid), 32'd0);
         @(posedge clk);
         #1;
      end

      // Backpressure: value held with InReady low for five cycles
      bif.OutReady = 1'b0;
      push(8'h80, 4'd1, 1'b0);
      send_beat(3'd7, 1'b1, 1'b0, c0);
      repeat (5) begin
         @(negedge clk);
         check("hold_valid", 32'(bif.OutValid), 32'd1);
         check("hold_value", 32'(bif.OutValue), 32'h80);
         check("hold_in_ready", 32'(bif.InReady), 32'd0);
      end
      @(posedge clk);
      #1;
      bif.OutReady = 1'b1;
      @(negedge clk);
      check("hold_in_ready_hs", 32'(bif.InReady), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_in_ready_after", 32'(bif.InReady), 32'd1);
      check("hold_valid_after", 32'(bif.OutValid), 32'd0);
      @(posedge clk);
      #1;

      // Reset mid-value discards the partial accumulation
      send_beat(3'd7, 1'b0, 1'b0, c0);
      send_beat(3'd6, 1'b0, 1'b0, c0);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(bif.OutValid), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      push(8'h01, 4'd1, 1'b0);
      send_beat(3'd0, 1'b1, 1'b0, c0);
      @(negedge clk);
      check("midrst_value", 32'(bif.OutValue), 32'h01);
      @(posedge clk);
      #1;

      // Back-to-back values: one idle InReady cycle between them
      push(8'h03, 4'd2, 1'b0);
      push(8'h80, 4'd1, 1'b0);
      send_beat(3'd1, 1'b0, 1'b0, c0);
      send_beat(3'd0, 1'b1, 1'b0, c0);
      send_beat(3'd7, 1'b1, 1'b0, c1);
      check("b2b_gap", 32'(c1 - c0), 32'd2);
      @(posedge clk);
      #1;

      // Count saturation with duplicate places
      push(8'hFF, 4'd8, ORD);
      for (int i = 0; i < 10; i++) begin
         p = (i < 8) ? 3'(7 - i) : 3'd0;
         send_beat(p, (i == 9), 1'b0, c0);
      end
      @(posedge clk);
      #1;

      // Empty beat after placed bits still outputs the accumulated bits
      push(8'h40, 4'd1, 1'b0);
      send_beat(3'd6, 1'b0, 1'b0, c0);
      send_beat(3'd2, 1'b0, 1'b1, c0);
      @(posedge clk);
      #1;

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
